// File: rtl/ipc_comlink.sv
// ipc_comlink: IPC-side COMCTRL/COMDATA link endpoint; strobes host frames, assembles RX words, shifts out reply bits
module ipc_comlink #(
    parameter int PULSE_W = 8,
    parameter int SETUP   = 4,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       comdata_in,
    output logic       comctrl,
    output logic       comdata_out,
    input  logic [3:0] rx_len,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    input  logic [3:0] tx_len,
    output logic       tx_busy,
    output logic       err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STROBE1 = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_STROBE2 = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;
    localparam logic [15:0] PW_END = 16'(PULSE_W - 1);
    localparam logic [15:0] SU_END = 16'(SETUP - 1);
    localparam logic [15:0] TO_END = 16'(TIMEOUT - 1);
    localparam logic [3:0]  SY_END = 4'(SYNC - 1);
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [3:0]  sync_cnt;
    logic [7:0]  rx_sh;
    logic [3:0]  rx_cnt;
    logic [3:0]  rx_len_q;
    logic        len_ok;
    logic [7:0]  tx_sh;
    logic [3:0]  tx_rem;
    logic [3:0]  rx_len_eff;
    logic [3:0]  tx_len_eff;
    logic [3:0]  cur_len;
    logic        start;
    logic        last_bit;
    logic        accept;
    assign comctrl    = !(state == S_STROBE1 || state == S_STROBE2);
    assign rx_len_eff = (rx_len == 4'd0) ? 4'd8 : rx_len;
    assign tx_len_eff = (tx_len == 4'd0) ? 4'd8 : tx_len;
    // word length is taken live for the very first bit after reset, then from the latched copy
    assign cur_len    = len_ok ? rx_len_q : rx_len_eff;
    assign start      = state == S_IDLE && !comdata_in && sync_cnt == SY_END;
    assign last_bit   = rx_cnt + 4'd1 == cur_len;
    // a load is also taken on the very edge that drives the final reply bit
    assign accept     = tx_load && (!tx_busy || (start && tx_rem == 4'd1));

    // link FSM with one shared phase counter; RX assembly and TX shifting ride on its transitions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sync_cnt    <= '0;
            err         <= 1'b0;
            rx_sh       <= '0;
            rx_cnt      <= '0;
            rx_len_q    <= '0;
            len_ok      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_sh       <= '0;
            tx_rem      <= '0;
            tx_busy     <= 1'b0;
            comdata_out <= 1'b1;
        end else if (ce) begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    sync_cnt <= (comdata_in || start) ? 4'd0 : sync_cnt + 4'd1;
                    if (start) begin
                        state       <= S_STROBE1;
                        cnt         <= '0;
                        err         <= 1'b0;
                        comdata_out <= tx_busy ? tx_sh[7] : 1'b1;
                        if (tx_busy) begin
                            tx_sh   <= tx_sh << 1;
                            tx_rem  <= tx_rem - 4'd1;
                            tx_busy <= tx_rem != 4'd1;
                        end
                    end
                end
                S_STROBE1: begin
                    cnt <= (cnt == PW_END) ? 16'd0 : cnt + 16'd1;
                    if (cnt == PW_END) state <= S_SETUP;
                end
                S_SETUP: begin
                    cnt <= (cnt == SU_END) ? 16'd0 : cnt + 16'd1;
                    if (cnt == SU_END) begin
                        state    <= S_STROBE2;
                        rx_sh    <= last_bit ? 8'd0 : {rx_sh[6:0], comdata_in};
                        rx_cnt   <= last_bit ? 4'd0 : rx_cnt + 4'd1;
                        rx_valid <= last_bit;
                        if (last_bit) rx_data <= {rx_sh[6:0], comdata_in};
                        if (last_bit || !len_ok) begin
                            rx_len_q <= rx_len_eff;
                            len_ok   <= 1'b1;
                        end
                    end
                end
                S_STROBE2: begin
                    cnt <= (cnt == PW_END) ? 16'd0 : cnt + 16'd1;
                    if (cnt == PW_END) state <= S_RECOVER;
                end
                S_RECOVER: begin
                    cnt <= (comdata_in || cnt == TO_END) ? 16'd0 : cnt + 16'd1;
                    if (comdata_in || cnt == TO_END) state <= S_IDLE;
                    if (!comdata_in && cnt == TO_END) err <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                tx_sh   <= tx_data << (4'd8 - tx_len_eff);
                tx_rem  <= tx_len_eff;
                tx_busy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ipc_comlink.sv
// tb_ipc_comlink: host-shifter model driving ipc_comlink with queue-based RX/TX reference checking
module tb_ipc_comlink;
    localparam int PW = 3;
    localparam int SU = 2;
    localparam int SY = 2;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       comdata_in = 1'b1;
    logic [3:0] rx_len = 4'd4;
    logic       tx_load = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic [3:0] tx_len = 4'd8;
    logic       comctrl;
    logic       comdata_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic       err;

    bit   ce_rand = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_rx[$];
    bit   exp_tx[$];
    int   rx_rd = 0;
    int   tx_rd = 0;
    int   strobes = 0;
    int   part = 0;
    int   part_n = 0;
    int   cur_len = 4;
    logic [7:0] got = 8'd0;

    ipc_comlink #(.PULSE_W(PW), .SETUP(SU), .SYNC(SY), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ce(ce), .comdata_in(comdata_in),
        .comctrl(comctrl), .comdata_out(comdata_out),
        .rx_len(rx_len), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_load(tx_load), .tx_data(tx_data), .tx_len(tx_len),
        .tx_busy(tx_busy), .err(err)
    );

    always #5 clk = ~clk;

    // clock enable: always on, or randomly gapped during the randomized rounds
    always @(posedge clk) begin
        #1 ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // compare process: strobe widths, reply bit per frame, tx_busy, received words
    logic prev_cc = 1'b1;
    int   low_cnt = 0;
    bit   par = 1'b0;
    bit   rv_done = 1'b0;
    logic eb;
    always @(negedge clk) begin
        if (reset) begin
            prev_cc = 1'b1;
            low_cnt = 0;
            par = 1'b0;
            rv_done = 1'b0;
        end else begin
            if (prev_cc && !comctrl) begin
                if (!par) begin
                    eb = (tx_rd < exp_tx.size()) ? exp_tx[tx_rd] : 1'b1;
                    if (tx_rd < exp_tx.size()) tx_rd++;
                    chk("comdata_out", comdata_out, eb);
                    chk("tx_busy_strobe", tx_busy, tx_rd < exp_tx.size());
                end
                par = !par;
                strobes++;
            end
            if (!prev_cc && comctrl) begin
                chk("strobe_width", low_cnt, PW);
                low_cnt = 0;
            end
            if (!comctrl && ce) low_cnt++;
            if (rx_valid && !rv_done) begin
                if (rx_rd < exp_rx.size()) begin
                    chk("rx_data", rx_data, exp_rx[rx_rd]);
                    rx_rd++;
                end else chk("rx_valid_unexpected", rx_valid, 0);
                rv_done = 1'b1;
            end
            if (!rx_valid) rv_done = 1'b0;
            prev_cc = comctrl;
        end
    end

    task automatic wait_cc(input logic v);
        int n = 0;
        while (comctrl !== v && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_comctrl", comctrl, v);
    endtask

    task automatic wait_ce(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (ce) k++;
            #1;
        end
    endtask

    task automatic send_frame(input logic d, input bit stuck);
        part = (part << 1) | d;
        part_n++;
        if (part_n == cur_len) begin
            exp_rx.push_back(part);
            part = 0;
            part_n = 0;
        end
        comdata_in = 1'b0;
        wait_cc(1'b0);
        got = {got[6:0], comdata_out};
        comdata_in = d;
        wait_cc(1'b1);
        wait_cc(1'b0);
        comdata_in = !stuck;
        wait_cc(1'b1);
        if (!stuck) wait_ce(2);
    endtask

    task automatic load_tx(input logic [7:0] d, input logic [3:0] l);
        int n;
        if (tx_rd == exp_tx.size()) begin
            n = (l == 4'd0) ? 8 : int'(l);
            for (int i = n - 1; i >= 0; i--) exp_tx.push_back(d[i]);
        end
        tx_data = d;
        tx_len = l;
        tx_load = 1'b1;
        do @(posedge clk); while (!ce);
        #1 tx_load = 1'b0;
        chk("tx_busy_load", tx_busy, tx_rd < exp_tx.size());
    endtask

    task automatic do_reset(input logic [3:0] l);
        reset = 1'b1;
        comdata_in = 1'b1;
        tx_load = 1'b0;
        rx_len = l;
        cur_len = (l == 4'd0) ? 8 : int'(l);
        part = 0;
        part_n = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_ce(2);
    endtask

    task automatic pad_rx();
        while (part_n != 0) send_frame(1'($urandom_range(0, 1)), 1'b0);
    endtask

    int   rd0;
    int   s0;
    logic rb;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_comctrl", comctrl, 1);
        chk("reset_comdata_out", comdata_out, 1);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;
        wait_ce(2);

        // D = 1,0,1,1 with a 4-bit word
        rd0 = rx_rd;
        send_frame(1'b1, 1'b0);
        send_frame(1'b0, 1'b0);
        send_frame(1'b1, 1'b0);
        send_frame(1'b1, 1'b0);
        chk("rx_word_0b", rx_data, 8'h0B);
        chk("rx_word_count", rx_rd - rd0, 1);

        // 8-bit reply A5 over 8 frames
        s0 = strobes;
        load_tx(8'hA5, 4'd8);
        for (int i = 0; i < 8; i++) send_frame(1'($urandom_range(0, 1)), 1'b0);
        chk("tx_a5_bits", got, 8'hA5);
        chk("tx_busy_done", tx_busy, 0);
        chk("strobes_8_frames", strobes - s0, 16);
        send_frame(1'b0, 1'b0);
        chk("tx_idle_one", got[0], 1);
        pad_rx();

        // single-sample glitch is not a start bit
        s0 = strobes;
        comdata_in = 1'b0;
        @(posedge clk);
        #1 comdata_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_no_strobe", strobes - s0, 0);

        // second load while busy is dropped
        load_tx(8'h3C, 4'd4);
        load_tx(8'hFF, 4'd8);
        for (int i = 0; i < 4; i++) send_frame(1'($urandom_range(0, 1)), 1'b0);
        chk("tx_ignored_load", tx_busy, 0);

        // stop bit never arrives
        send_frame(1'b1, 1'b1);
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("err_before_timeout", err, 0);
        @(posedge clk);
        #1;
        chk("err_at_timeout", err, 1);
        comdata_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", err, 1);
        send_frame(1'b0, 1'b0);
        chk("err_cleared", err, 0);
        pad_rx();
        chk("rx_all_words", rx_rd, exp_rx.size());

        // reset while the first strobe is low
        do_reset(4'd4);
        send_frame(1'b1, 1'b0);
        send_frame(1'b1, 1'b0);
        comdata_in = 1'b0;
        wait_cc(1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_comctrl", comctrl, 1);
        chk("midreset_rx_valid", rx_valid, 0);
        chk("midreset_err", err, 0);
        rd0 = rx_rd;
        do_reset(4'd4);
        chk("midreset_no_word", rx_rd - rd0, 0);
        for (int i = 0; i < 4; i++) send_frame(1'($urandom_range(0, 1)), 1'b0);
        chk("midreset_fresh_word", rx_rd - rd0, 1);

        // randomized rounds with gapped clock enable
        ce_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            do_reset(4'($urandom_range(0, 8)));
            for (int w = 0; w < 3; w++) begin
                for (int b = 0; b < cur_len; b++) begin
                    if ($urandom_range(0, 3) == 0) load_tx(8'($urandom), 4'($urandom_range(0, 8)));
                    send_frame(1'($urandom_range(0, 1)), 1'b0);
                end
            end
            for (int g = 0; g < 10 && tx_rd < exp_tx.size(); g++) send_frame(1'($urandom_range(0, 1)), 1'b0);
            pad_rx();
            chk("rand_rx_all", rx_rd, exp_rx.size());
            chk("rand_tx_all", tx_rd, exp_tx.size());
            chk("rand_tx_busy", tx_busy, 0);
        end
        ce_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
